// File: rtl/y86_seq_ctrl.sv
// Multi-cycle sequencer for the Y86 SEQ core.
// Steps each instruction through fetch, decode, execute, memory, writeback and PC update,
// runs the memory handshakes, reports processor status and counts retired instructions.
// Optional feature macro: Y86_SINGLE_STEP_EN adds a 'step' input; after each PC update the
// sequencer rests in IDLE until a rising edge of step (or start).
module y86_seq_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TMO_W       = 4,
  parameter int unsigned MEM_TIMEOUT = 12
) (
  input  logic             clk,
  input  logic             rst,
`ifdef Y86_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             start,
  input  logic [3:0]       icode_i,
  input  logic             instr_valid_i,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             fetch_en,
  output logic             dec_en,
  output logic             exe_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic [1:0]       stat,
  output logic             running,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StExecute, StMemory, StWriteback, StPcupd, StHalted, StError
  } state_e;

  localparam logic [1:0] StatAok = 2'b00;
  localparam logic [1:0] StatHlt = 2'b01;
  localparam logic [1:0] StatAdr = 2'b10;
  localparam logic [1:0] StatIns = 2'b11;

  // Counter value seen on the last permitted wait cycle.
  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       stat_q, stat_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             icode_mem, icode_we, icode_wb;
  logic             go;

`ifdef Y86_SINGLE_STEP_EN
  logic step_q;

  // Registered copy of step for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) step_q <= 1'b0;
    else      step_q <= step;
  end

  assign go = start | (step & ~step_q);
`else
  assign go = start;
`endif

  // Per-icode attributes: memory access, memory write, register writeback.
  always_comb begin
    icode_mem = 1'b0;
    icode_we  = 1'b0;
    icode_wb  = 1'b0;
    case (icode_i)
      4'h2, 4'h3, 4'h6: icode_wb = 1'b1;
      4'h4: begin
        icode_mem = 1'b1;
        icode_we  = 1'b1;
      end
      4'h5, 4'h9, 4'hB: begin
        icode_mem = 1'b1;
        icode_wb  = 1'b1;
      end
      4'h8, 4'hA: begin
        icode_mem = 1'b1;
        icode_we  = 1'b1;
        icode_wb  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, status, timeout and retire-count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      stat_q    <= StatAok;
      tmo_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic and stage strobes decoded from the current state.
  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    tmo_d     = tmo_q;
    retired_d = retired_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    fetch_en  = 1'b0;
    dec_en    = 1'b0;
    exe_en    = 1'b0;
    wb_en     = 1'b0;
    pc_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StFetch;
          tmo_d   = '0;
        end
      end
      StFetch: begin
        imem_req = 1'b1;
        // An ack on the final wait cycle still wins over the timeout.
        if (imem_ack) begin
          fetch_en = 1'b1;
          state_d  = StDecode;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TmoLast) begin
            state_d = StError;
            stat_d  = StatAdr;
          end
        end
      end
      StDecode: begin
        dec_en = 1'b1;
        if (icode_i == 4'h0) begin
          state_d = StHalted;
          stat_d  = StatHlt;
        end else if (!instr_valid_i || icode_i > 4'hB) begin
          state_d = StError;
          stat_d  = StatIns;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        exe_en = 1'b1;
        if (icode_mem) begin
          state_d = StMemory;
          tmo_d   = '0;
        end else begin
          state_d = StWriteback;
        end
      end
      StMemory: begin
        dmem_req = 1'b1;
        dmem_we  = icode_we;
        if (dmem_ack) begin
          state_d = StWriteback;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TmoLast) begin
            state_d = StError;
            stat_d  = StatAdr;
          end
        end
      end
      StWriteback: begin
        wb_en   = icode_wb;
        state_d = StPcupd;
      end
      StPcupd: begin
        pc_en     = 1'b1;
        retired_d = retired_q + 1'b1;
`ifdef Y86_SINGLE_STEP_EN
        state_d   = StIdle;
`else
        state_d   = StFetch;
        tmo_d     = '0;
`endif
      end
      StHalted, StError: ;
      default: state_d = StIdle;
    endcase
  end

  assign running = !(state_q inside {StIdle, StHalted, StError});
  assign stat    = stat_q;
  assign retired = retired_q;

endmodule
